// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu fetch path: PC select encoding and fetch FSM states.
package mycpu_pkg;

  localparam int unsigned AwDefault = 16;
  localparam int unsigned DwDefault = 16;

  typedef enum logic [1:0] {
    PC_NOP = 2'b00,
    PC_INC = 2'b01,
    PC_BRA = 2'b10,
    PC_JMP = 2'b11
  } ps_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StUpd
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: single-outstanding imem read, hands the word to decode and
// drives the PC select/offset/target interface. All outputs are registered.
module fetch_ctrl
  import mycpu_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  input  logic [AW-1:0] pc_in,
  output ps_t           ps_out,
  output logic [AW-1:0] ia_out,
  output logic [AW-1:0] ra_out,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          ir_valid,
  output logic [DW-1:0] ir_out,
  output logic [AW-1:0] ir_pc,
  input  logic          dec_ready,
  input  logic          br_req,
  input  logic [AW-1:0] br_offset,
  input  logic          jmp_req,
  input  logic [AW-1:0] jmp_target,
  output logic          redir_ack
);

  fetch_state_t  state_q, state_d;
  logic          drop_q, drop_d;
  ps_t           ps_q, ps_d;
  logic [AW-1:0] ia_q, ia_d, ra_q, ra_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ir_valid_q, ir_valid_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          ack_q, ack_d;
  logic          redir, accept;

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    ps_d       = PC_NOP;
    ia_d       = ia_q;
    ra_d       = ra_q;
    req_d      = req_q;
    addr_d     = addr_q;
    ir_valid_d = ir_valid_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ack_d      = 1'b0;
    accept     = 1'b0;
    // A requester still sees its request high during the ack cycle; don't take it twice.
    redir      = (jmp_req | br_req) & ~ack_q;

    unique case (state_q)
      StIdle: begin
        if (redir) begin
          accept  = 1'b1;
          state_d = StUpd;
        end else if (fetch_en) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // First REQ cycle samples pc_in, which has settled by now after the UPD cycle.
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pc_in;
        end else if (imem_gnt) begin
          req_d   = 1'b0;
          state_d = StWait;
          if (redir) begin
            accept = 1'b1;
            drop_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (drop_q || redir) begin
            accept  = redir;
            drop_d  = 1'b0;
            state_d = StUpd;
          end else begin
            ir_d       = imem_rdata;
            ir_pc_d    = addr_q;
            ir_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else if (redir) begin
          accept = 1'b1;
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (redir) begin
          accept     = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = StUpd;
        end else if (dec_ready) begin
          ps_d       = PC_INC;
          ir_valid_d = 1'b0;
          state_d    = StUpd;
        end
      end
      StUpd: begin
        if (redir) begin
          accept = 1'b1;
        end else begin
          state_d = fetch_en ? StReq : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      ack_d = 1'b1;
      if (jmp_req) begin
        ps_d = PC_JMP;
        ra_d = jmp_target;
      end else begin
        ps_d = PC_BRA;
        ia_d = br_offset;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      drop_q     <= 1'b0;
      ps_q       <= PC_NOP;
      ia_q       <= '0;
      ra_q       <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      ir_valid_q <= 1'b0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      ps_q       <= ps_d;
      ia_q       <= ia_d;
      ra_q       <= ra_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      ir_valid_q <= ir_valid_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ack_q      <= ack_d;
    end
  end

  assign ps_out    = ps_q;
  assign ia_out    = ia_q;
  assign ra_out    = ra_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_valid  = ir_valid_q;
  assign ir_out    = ir_q;
  assign ir_pc     = ir_pc_q;
  assign redir_ack = ack_q;

endmodule
